// File: rtl/effect_chain_sequencer_pkg.sv
// Shared types and constants for the effect chain sequencer.
// Holds the FSM state enum, slot index width and overrun counter width.
package effect_chain_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      EMIT
   } state_t;

   localparam int MAX_EFFECTS = 8;
   localparam int SLOT_W      = $clog2(MAX_EFFECTS);
   localparam int OVR_W       = 8;

endpackage

// File: rtl/effect_chain_sequencer_if.sv
// Bus between the sequencer, the codec/DAC side and the effect slots.
// master: sequencer side; slave: codec, DAC and effect slots.
interface effect_chain_sequencer_if
   import effect_chain_pkg::*;
#(
   parameter int DATA_WIDTH  = 16,
   parameter int NUM_EFFECTS = 4
);

   logic                              sample_valid;
   logic [DATA_WIDTH-1:0]             sample_in;
   logic [NUM_EFFECTS-1:0]            effect_enable;
   logic [NUM_EFFECTS-1:0]            effect_cs;
   logic [NUM_EFFECTS-1:0]            effect_my_turn;
   logic [NUM_EFFECTS-1:0]            effect_done;
   logic [DATA_WIDTH-1:0]             effect_data_in;
   logic [NUM_EFFECTS*DATA_WIDTH-1:0] effect_data_out;
   logic [DATA_WIDTH-1:0]             sample_out;
   logic                              sample_out_valid;
   logic                              busy;
   logic [OVR_W-1:0]                  overrun_cnt;
   logic [NUM_EFFECTS-1:0]            timeout_flags;

   modport master (
      input  sample_valid,
      input  sample_in,
      input  effect_enable,
      input  effect_done,
      input  effect_data_out,
      output effect_cs,
      output effect_my_turn,
      output effect_data_in,
      output sample_out,
      output sample_out_valid,
      output busy,
      output overrun_cnt,
      output timeout_flags
   );

   modport slave (
      output sample_valid,
      output sample_in,
      output effect_enable,
      output effect_done,
      output effect_data_out,
      input  effect_cs,
      input  effect_my_turn,
      input  effect_data_in,
      input  sample_out,
      input  sample_out_valid,
      input  busy,
      input  overrun_cnt,
      input  timeout_flags
   );

endinterface

// File: rtl/effect_chain_sequencer_seq_watchdog.sv
// Stuck-effect watchdog: counts cycles while a slot holds its grant.
// Ports: clk, rst (async active-low), clear, run in; expired out.
module seq_watchdog #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic run,
   output logic expired
);

   logic [7:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (run) begin
         cnt <= cnt + 8'd1;
      end
   end

   assign expired = (cnt == 8'(TIMEOUT_CYCLES));

endmodule

// File: rtl/effect_chain_sequencer.sv
// Walks each codec sample through the effect slots in fixed order.
// Ports: clk, rst (async active-low), bus (master modport).
// Optional stuck-slot watchdog enabled by defining SEQ_WATCHDOG_EN.
module effect_chain_sequencer
   import effect_chain_pkg::*;
#(
   parameter int DATA_WIDTH     = 16,
   parameter int NUM_EFFECTS    = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input logic                    clk,
   input logic                    rst,
   effect_chain_sequencer_if.master bus
);

   localparam int DW = DATA_WIDTH;
   localparam int N  = NUM_EFFECTS;

   if (N < 1 || N > MAX_EFFECTS) begin : g_bad_n
      $error("NUM_EFFECTS out of range");
   end
   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_to
      $error("TIMEOUT_CYCLES out of range");
   end

   state_t            state, state_nx;
   logic [SLOT_W-1:0] slot, slot_nx;
   logic [DW-1:0]     work, work_nx;
   logic [N-1:0]      en_snap;
   logic [N-1:0]      sel;
   logic [N-1:0]      grant;
   logic [DW-1:0]     sel_data;
   logic              sel_en;
   logic              sel_done;
   logic              last;
   logic              adv;
   logic              wd_exp;
   logic [DW-1:0]     out_q;
   logic              out_vld;
   logic [OVR_W-1:0]  ovr;

   // One-hot slot decode avoids index-width mismatches for small N.
   always_comb begin
      sel      = '0;
      sel_data = '0;
      for (int i = 0; i < N; i++) begin
         sel[i] = (slot == SLOT_W'(i));
         if (sel[i]) begin
            sel_data = bus.effect_data_out[i*DW +: DW];
         end
      end
   end

   assign sel_en   = |(sel & en_snap);
   assign last     = (slot == SLOT_W'(N - 1));
   // An expired slot loses its grant in the same cycle it times out.
   assign grant    = (state == RUN && !wd_exp) ? (sel & en_snap) : '0;
   assign sel_done = |(grant & bus.effect_done);

   always_comb begin
      state_nx = state;
      slot_nx  = slot;
      work_nx  = work;
      adv      = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.sample_valid) begin
               work_nx  = bus.sample_in;
               slot_nx  = '0;
               state_nx = RUN;
            end
         end
         RUN: begin
            if (!sel_en) begin
               adv = 1'b1;
            end else if (sel_done) begin
               work_nx = sel_data;
               adv     = 1'b1;
            end else if (wd_exp) begin
               adv = 1'b1;
            end
            if (adv) begin
               if (last) begin
                  state_nx = EMIT;
               end else begin
                  slot_nx = slot + 1'b1;
               end
            end
         end
         EMIT: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         slot    <= '0;
         work    <= '0;
         en_snap <= '0;
         out_q   <= '0;
         out_vld <= 1'b0;
         ovr     <= '0;
      end else begin
         state   <= state_nx;
         slot    <= slot_nx;
         work    <= work_nx;
         out_vld <= (state == EMIT);
         if (state == IDLE && bus.sample_valid) begin
            en_snap <= bus.effect_enable;
         end
         if (state == EMIT) begin
            out_q <= work;
         end
         if (state != IDLE && bus.sample_valid && ovr != '1) begin
            ovr <= ovr + 1'b1;
         end
      end
   end

`ifdef SEQ_WATCHDOG_EN
   logic [N-1:0] tflags;

   seq_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_wd (
      .clk    (clk),
      .rst    (rst),
      .clear  (adv),
      .run    (|grant),
      .expired(wd_exp)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tflags <= '0;
      end else if (state == RUN && sel_en && wd_exp) begin
         tflags <= tflags | sel;
      end
   end

   assign bus.timeout_flags = tflags;
`else
   assign wd_exp            = 1'b0;
   assign bus.timeout_flags = '0;
`endif

   assign bus.effect_cs        = grant;
   assign bus.effect_my_turn   = grant;
   assign bus.effect_data_in   = work;
   assign bus.sample_out       = out_q;
   assign bus.sample_out_valid = out_vld;
   assign bus.busy             = (state != IDLE);
   assign bus.overrun_cnt      = ovr;

endmodule

// File: tb/tb_effect_chain_sequencer.sv
// Directed bench for effect_chain_sequencer with four +1 effect models.
// Define SEQ_WATCHDOG_EN to also exercise the stuck-slot watchdog.
module tb_effect_chain_sequencer;

   logic clk;
   logic rst;
   logic [3:0] stuck;
   int n_pass;
   int n_total;
   logic [3:0] cs_seen;
   int mt1_cnt;

   effect_chain_sequencer_if #(
      .DATA_WIDTH (16),
      .NUM_EFFECTS(4)
   ) bus ();

   effect_chain_sequencer #(
      .DATA_WIDTH    (16),
      .NUM_EFFECTS   (4),
      .TIMEOUT_CYCLES(255)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Effect model: done one cycle after the grant, result = input + 1.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.effect_done <= '0;
      end else begin
         bus.effect_done <= bus.effect_my_turn & ~stuck;
      end
   end

   always_comb begin
      bus.effect_data_out = '0;
      for (int i = 0; i < 4; i++) begin
         bus.effect_data_out[i*16 +: 16] = bus.effect_data_in + 16'd1;
      end
   end

   // mode 1: extra strobe at t+3; mode 2: invert enables mid-chain.
   task automatic run_sample(
      input  logic [15:0] din,
      input  logic [3:0]  en,
      input  int          mode,
      input  int          limit,
      output int          lat
   );
      cs_seen = '0;
      mt1_cnt = 0;
      lat     = 0;
      @(negedge clk);
      bus.sample_valid  = 1'b1;
      bus.sample_in     = din;
      bus.effect_enable = en;
      @(negedge clk);
      bus.sample_valid = 1'b0;
      while (!bus.sample_out_valid && lat < limit) begin
         cs_seen = cs_seen | bus.effect_cs;
         if (bus.effect_my_turn[1]) mt1_cnt++;
         if (mode == 1 && lat == 2) bus.sample_valid = 1'b1;
         if (mode == 1 && lat == 3) bus.sample_valid = 1'b0;
         if (mode == 2 && lat == 2) bus.effect_enable = ~en;
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset();
      #1;
      n_total++;
      if (bus.busy !== 1'b0 || bus.effect_my_turn !== 4'h0
          || bus.effect_cs !== 4'h0)
         $display("FAIL reset_ctrl: busy=%b turn=%b cs=%b want 0 0 0",
                  bus.busy, bus.effect_my_turn, bus.effect_cs);
      else n_pass++;
      n_total++;
      if (bus.sample_out !== 16'h0 || bus.sample_out_valid !== 1'b0)
         $display("FAIL reset_out: out=%h vld=%b want 0000 0",
                  bus.sample_out, bus.sample_out_valid);
      else n_pass++;
      n_total++;
      if (bus.overrun_cnt !== 8'h0 || bus.timeout_flags !== 4'h0
          || bus.effect_data_in !== 16'h0)
         $display("FAIL reset_cnt: ovr=%0d to=%b din=%h want 0 0 0",
                  bus.overrun_cnt, bus.timeout_flags,
                  bus.effect_data_in);
      else n_pass++;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_total++;
      if (bus.busy !== 1'b0)
         $display("FAIL reset_idle: busy=%b want 0", bus.busy);
      else n_pass++;
   endtask

   task automatic test_all_enabled();
      int lat;
      run_sample(16'h0010, 4'hF, 0, 40, lat);
      n_total++;
      if (lat !== 9)
         $display("FAIL all_lat: got %0d want 9", lat);
      else n_pass++;
      n_total++;
      if (bus.sample_out !== 16'h0014)
         $display("FAIL all_out: got %h want 0014", bus.sample_out);
      else n_pass++;
      n_total++;
      if (cs_seen !== 4'hF)
         $display("FAIL all_cs: got %b want 1111", cs_seen);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if (bus.sample_out_valid !== 1'b0 || bus.busy !== 1'b0
          || bus.sample_out !== 16'h0014)
         $display("FAIL all_pulse: vld=%b busy=%b out=%h want 0 0 0014",
                  bus.sample_out_valid, bus.busy, bus.sample_out);
      else n_pass++;
   endtask

   task automatic test_partial();
      int lat;
      run_sample(16'h0010, 4'b0101, 0, 40, lat);
      n_total++;
      if (lat !== 7)
         $display("FAIL part_lat: got %0d want 7", lat);
      else n_pass++;
      n_total++;
      if (bus.sample_out !== 16'h0012)
         $display("FAIL part_out: got %h want 0012", bus.sample_out);
      else n_pass++;
      n_total++;
      if (cs_seen !== 4'b0101)
         $display("FAIL part_cs: got %b want 0101", cs_seen);
      else n_pass++;
   endtask

   task automatic test_all_disabled();
      int lat;
      run_sample(16'h8234, 4'b0000, 0, 40, lat);
      n_total++;
      if (lat !== 5)
         $display("FAIL dis_lat: got %0d want 5", lat);
      else n_pass++;
      n_total++;
      if (bus.sample_out !== 16'h8234 || cs_seen !== 4'h0)
         $display("FAIL dis_out: out=%h cs=%b want 8234 0000",
                  bus.sample_out, cs_seen);
      else n_pass++;
   endtask

   task automatic test_overrun();
      int lat;
      int k;
      run_sample(16'h0010, 4'hF, 1, 40, lat);
      n_total++;
      if (lat !== 9 || bus.sample_out !== 16'h0014)
         $display("FAIL ovr_chain: lat=%0d out=%h want 9 0014",
                  lat, bus.sample_out);
      else n_pass++;
      n_total++;
      if (bus.overrun_cnt !== 8'd1)
         $display("FAIL ovr_one: got %0d want 1", bus.overrun_cnt);
      else n_pass++;
      @(negedge clk);
      bus.sample_valid = 1'b1;
      repeat (400) @(negedge clk);
      bus.sample_valid = 1'b0;
      k = 0;
      while (bus.busy && k < 40) begin
         @(negedge clk);
         k++;
      end
      n_total++;
      if (bus.busy !== 1'b0)
         $display("FAIL ovr_drain: busy=%b want 0", bus.busy);
      else n_pass++;
      n_total++;
      if (bus.overrun_cnt !== 8'd255)
         $display("FAIL ovr_sat: got %0d want 255", bus.overrun_cnt);
      else n_pass++;
   endtask

   task automatic test_enable_toggle();
      int lat;
      run_sample(16'h0100, 4'b1010, 2, 40, lat);
      n_total++;
      if (cs_seen !== 4'b1010)
         $display("FAIL tog_cs: got %b want 1010", cs_seen);
      else n_pass++;
      n_total++;
      if (lat !== 7 || bus.sample_out !== 16'h0102)
         $display("FAIL tog_out: lat=%0d out=%h want 7 0102",
                  lat, bus.sample_out);
      else n_pass++;
   endtask

   task automatic test_watchdog();
      int lat;
`ifdef SEQ_WATCHDOG_EN
      stuck = 4'b0010;
      run_sample(16'h0010, 4'hF, 0, 400, lat);
      stuck = 4'b0000;
      n_total++;
      if (mt1_cnt !== 255)
         $display("FAIL wd_turn: got %0d want 255", mt1_cnt);
      else n_pass++;
      n_total++;
      if (lat !== 263 || bus.sample_out !== 16'h0013)
         $display("FAIL wd_out: lat=%0d out=%h want 263 0013",
                  lat, bus.sample_out);
      else n_pass++;
      n_total++;
      if (bus.timeout_flags !== 4'b0010)
         $display("FAIL wd_flag: got %b want 0010", bus.timeout_flags);
      else n_pass++;
      run_sample(16'h0020, 4'hF, 0, 40, lat);
      n_total++;
      if (bus.timeout_flags !== 4'b0010 || bus.sample_out !== 16'h0024)
         $display("FAIL wd_sticky: to=%b out=%h want 0010 0024",
                  bus.timeout_flags, bus.sample_out);
      else n_pass++;
`else
      run_sample(16'h0020, 4'hF, 0, 40, lat);
      n_total++;
      if (bus.timeout_flags !== 4'h0 || bus.sample_out !== 16'h0024)
         $display("FAIL wd_off: to=%b out=%h want 0000 0024",
                  bus.timeout_flags, bus.sample_out);
      else n_pass++;
`endif
   endtask

   task automatic test_reset_mid_chain();
      int lat;
      int k;
      @(negedge clk);
      bus.sample_valid  = 1'b1;
      bus.sample_in     = 16'h0050;
      bus.effect_enable = 4'hF;
      @(negedge clk);
      bus.sample_valid = 1'b0;
      k = 0;
      while (!bus.effect_my_turn[2] && k < 20) begin
         @(negedge clk);
         k++;
      end
      n_total++;
      if (bus.effect_my_turn[2] !== 1'b1)
         $display("FAIL rmid_grant: turn=%b want slot 2", bus.effect_my_turn);
      else n_pass++;
      #2;
      rst = 1'b0;
      #1;
      n_total++;
      if (bus.effect_my_turn !== 4'h0 || bus.effect_cs !== 4'h0
          || bus.busy !== 1'b0)
         $display("FAIL rmid_async: turn=%b cs=%b busy=%b want 0 0 0",
                  bus.effect_my_turn, bus.effect_cs, bus.busy);
      else n_pass++;
      n_total++;
      if (bus.sample_out !== 16'h0 || bus.overrun_cnt !== 8'h0
          || bus.timeout_flags !== 4'h0 || bus.effect_data_in !== 16'h0)
         $display("FAIL rmid_clr: out=%h ovr=%0d to=%b din=%h want 0",
                  bus.sample_out, bus.overrun_cnt, bus.timeout_flags,
                  bus.effect_data_in);
      else n_pass++;
      @(negedge clk);
      rst = 1'b1;
      run_sample(16'h0100, 4'hF, 0, 40, lat);
      n_total++;
      if (lat !== 9 || bus.sample_out !== 16'h0104)
         $display("FAIL rmid_next: lat=%0d out=%h want 9 0104",
                  lat, bus.sample_out);
      else n_pass++;
      n_total++;
      if (bus.overrun_cnt !== 8'h0)
         $display("FAIL rmid_ovr: got %0d want 0", bus.overrun_cnt);
      else n_pass++;
   endtask

   initial begin
      n_pass            = 0;
      n_total           = 0;
      cs_seen           = '0;
      mt1_cnt           = 0;
      stuck             = '0;
      rst               = 1'b0;
      bus.sample_valid  = 1'b0;
      bus.sample_in     = '0;
      bus.effect_enable = '0;
      test_reset();
      test_all_enabled();
      test_partial();
      test_all_disabled();
      test_overrun();
      test_enable_toggle();
      test_watchdog();
      test_reset_mid_chain();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
